data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 267 ++++++++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//   Data-memory slave for a RISC-V memory stage. It accepts one load/store
//   request at a time and waits WAIT_CYCLES cycles (plus one cycle spent in
//   WAIT). It then performs a little-endian byte/halfword/word access on
//   internal storage and holds the response until the pipeline takes it.
//
// Ports
//   clk1        : single clock, rising edge
//   rst         : synchronous active-high reset (storage is not cleared)
//   req_valid   : request present
//   req_ready   : responder idle and able to accept
//   req_we      : 1 = store, 0 = load
//   req_addr    : byte address
//   req_wdata   : right-aligned store data
//   req_funct3  : RISC-V load/store funct3
//   rsp_valid   : response available
//   rsp_ready   : response accepted by pipeline
//   rsp_rdata   : extended load data, 0 for stores and errors
//   rsp_err     : misaligned / out-of-range / illegal funct3
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_e;

  // -------------------------------------------------------------------------
  // Decode helpers
  // -------------------------------------------------------------------------
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    case (f3)
      3'b000, 3'b001, 3'b010: bad = 1'b0;
      3'b100, 3'b101:         bad = we;   // unsigned variants exist only for loads
      default:                bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = lane[0];
      2'b10:   bad = (lane != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_strb(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] strb;
    case (f3[1:0])
      2'b00:   strb = 4'b0001 << lane;
      2'b01:   strb = 4'b0011 << lane;
      2'b10:   strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // w is the storage word already shifted so the addressed byte is at [7:0]
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {{24{w[7]}}, w[7:0]};
      3'b001:  r = {{16{w[15]}}, w[15:0]};
      3'b010:  r = w;
      3'b100:  r = {24'h000000, w[7:0]};
      3'b101:  r = {16'h0000, w[15:0]};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          access_s;
  logic          in_range_s;
  logic          err_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   word_s;
  logic [31:0]   shifted_s;
  logic [31:0]   acc_rdata_s;
  logic [3:0]    strb_s;
  logic [31:0]   wdata_sh_s;
  logic          mem_we_s;

  // Access evaluation on the latched request
  always_comb begin
    access_s    = (state_q == S_WAIT) && (cnt_q == 4'd0);
    in_range_s  = ({2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS));
    err_s       = f3_illegal(we_q, funct3_q) || misaligned(funct3_q, addr_q[1:0]) || !in_range_s;
    idx_s       = addr_q[AW+1:2];
    if (in_range_s) begin
      word_s = mem_q[idx_s];
    end else begin
      word_s = 32'h0000_0000;
    end
    shifted_s   = word_s >> {addr_q[1:0], 3'b000};
    if (err_s || we_q) begin
      acc_rdata_s = 32'h0000_0000;
    end else begin
      acc_rdata_s = load_extend(funct3_q, shifted_s);
    end
    strb_s      = lane_strb(funct3_q, addr_q[1:0]);
    wdata_sh_s  = wdata_q << {addr_q[1:0], 3'b000};
    // rst at the access edge aborts the transaction, so it also blocks the write
    mem_we_s    = access_s && !err_s && we_q && !rst;
  end

  // State register and registered outputs
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      funct3_q    <= 3'b000;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state, wait counter and request capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d  = S_WAIT;
          cnt_d    = 4'(WAIT_CYCLES);
          we_d     = req_we;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output next values; response fields are frozen while waiting for rsp_ready
  always_comb begin
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_WAIT: begin
        if (access_s) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = acc_rdata_s;
          rsp_err_d   = err_s;
        end else begin
          rsp_valid_d = 1'b0;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0000_0000;
          rsp_err_d   = 1'b0;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      S_IDLE: begin
        rsp_valid_d = 1'b0;
      end
      default: begin
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0000_0000;
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  // Byte-lane store; deliberately outside the reset so contents survive rst
  always_ff @(posedge clk1) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_s[b]) begin
          mem_q[idx_s][8*b +: 8] <= wdata_sh_s[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int W = 2;

  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_funct3 = 3'b000;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad = 0;
  logic [31:0] got_rdata;
  logic        got_err;

  // byte-addressed reference storage (first 1 KiB = 256 words)
  logic [7:0] ref_mem [1024];

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W)) dut (
    .clk1(clk1), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: derive result from access size, alignment and range rules
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, output logic [31:0] rd, output logic err);
    int size;
    case (f3[1:0])
      2'b00: size = 1;
      2'b01: size = 2;
      2'b10: size = 4;
      default: size = 0;
    endcase
    err = 1'b0;
    if (size == 0) err = 1'b1;
    if (f3[2] && (we || size == 4)) err = 1'b1;
    if (size != 0 && (addr % size) != 0) err = 1'b1;
    if ((addr / 4) >= 256) err = 1'b1;
    rd = 32'h0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < size; k++) ref_mem[addr + k] = wdata[8*k +: 8];
      end else begin
        for (int k = 0; k < size; k++) rd[8*k +: 8] = ref_mem[addr + k];
        if (!f3[2] && size < 4 && rd[8*size-1]) rd = rd | (32'hFFFF_FFFF << (8*size));
      end
    end
  endtask

  // One full transaction; entered and left at a negedge
  task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] f3, input int hold);
    logic [31:0] exp_rd;
    logic        exp_err;
    int n;
    model(we, addr, wdata, f3, exp_rd, exp_err);
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk1);
      n++;
    end
    chk("ready_wait", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    @(posedge clk1);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    n = 0;
    @(negedge clk1);
    while (!rsp_valid && n < 20) begin
      @(negedge clk1);
      n++;
    end
    chk("latency", n, W + 1);
    chk("rdata", rsp_rdata, exp_rd);
    chk("err", {31'b0, rsp_err}, {31'b0, exp_err});
    got_rdata = rsp_rdata;
    got_err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk1);
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk1);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk1);
    chk("ready_after_ack", {31'b0, req_ready}, 32'd1);
    chk("valid_after_ack", {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] a;

    // reset state
    repeat (3) @(negedge clk1);
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk1);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);

    // known contents for the first 16 words
    for (int i = 0; i < 16; i++) run(1'b1, 32'(4*i), $urandom, 3'b010, 0);

    // directed load/store checks
    run(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0);
    chk("sw_err", {31'b0, got_err}, 32'd0);
    run(1'b0, 32'h10, 32'h0, 3'b010, 0);
    chk("lw_10", got_rdata, 32'hDEADBEEF);
    run(1'b0, 32'h13, 32'h0, 3'b000, 0);
    chk("lb_13", got_rdata, 32'hFFFFFFDE);
    run(1'b0, 32'h13, 32'h0, 3'b100, 0);
    chk("lbu_13", got_rdata, 32'h000000DE);
    run(1'b0, 32'h10, 32'h0, 3'b001, 0);
    chk("lh_10", got_rdata, 32'hFFFFBEEF);
    run(1'b0, 32'h12, 32'h0, 3'b101, 0);
    chk("lhu_12", got_rdata, 32'h0000DEAD);
    run(1'b1, 32'h11, 32'h12, 3'b000, 0);
    run(1'b0, 32'h10, 32'h0, 3'b010, 0);
    chk("sb_merge", got_rdata, 32'hDEAD12EF);

    // error cases leave storage untouched
    run(1'b0, 32'h12, 32'h0, 3'b010, 0);
    chk("lw_mis_err", {31'b0, got_err}, 32'd1);
    run(1'b1, 32'h11, 32'hFFFF, 3'b001, 0);
    chk("sh_mis_err", {31'b0, got_err}, 32'd1);
    run(1'b1, 32'h10, 32'h0, 3'b011, 0);
    chk("f3_011_err", {31'b0, got_err}, 32'd1);
    run(1'b0, 32'h400, 32'h0, 3'b010, 0);
    chk("range_err", {31'b0, got_err}, 32'd1);
    chk("range_rdata", got_rdata, 32'd0);
    run(1'b0, 32'h10, 32'h0, 3'b010, 0);
    chk("unchanged", got_rdata, 32'hDEAD12EF);

    // long stall in RESP
    run(1'b0, 32'h10, 32'h0, 3'b000, 5);

    // reset during WAIT aborts a store
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk1); n++; end
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_funct3 = 3'b010;
    @(posedge clk1);
    #1;
    req_valid = 1'b0;
    @(negedge clk1);
    rst = 1'b1;
    @(negedge clk1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk1);
      chk("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    run(1'b0, 32'h20, 32'h0, 3'b010, 0);

    // reset during RESP drops the response
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk1); n++; end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
    @(posedge clk1);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk1); n++; end
    chk("resp_seen", {31'b0, rsp_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk1);
    rst = 1'b0;
    chk("drop_valid", {31'b0, rsp_valid}, 32'd0);
    chk("drop_rdata", rsp_rdata, 32'd0);
    @(negedge clk1);
    chk("drop_ready", {31'b0, req_ready}, 32'd1);

    // randomized traffic
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 9) == 0) a = 32'h400 + $urandom_range(0, 63);
      else a = $urandom_range(0, 63);
      run(1'($urandom), a, $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
